// File: rtl/arm_multicycle_ctrl_if.sv
// Control and status bundle between the multicycle ARM controller (master) and its datapath (slave).
interface arm_multicycle_ctrl_if #(
    parameter int ALUCTL_W = 3
);
    logic [31:0]         instr;
    logic [3:0]          alu_flags;
    logic                mem_ready;
    logic                pc_write;
    logic                adr_src;
    logic                mem_write;
    logic                ir_write;
    logic [1:0]          result_src;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALUCTL_W-1:0] alu_control;
    logic [1:0]          imm_src;
    logic [1:0]          reg_src;
    logic                reg_write;
    logic                link_write;
    logic [3:0]          state_o;
    logic                bus_error;

    modport master (
        input  instr, alu_flags, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
               alu_control, imm_src, reg_src, reg_write, link_write, state_o, bus_error
    );

    modport slave (
        output instr, alu_flags, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
               alu_control, imm_src, reg_src, reg_write, link_write, state_o, bus_error
    );
endinterface

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM control FSM: fetch/decode/execute sequencing, NZCV flags, memory wait timeout.
// Optional BL support (link to R14) is enabled by defining BRANCH_LINK_EN.
module arm_multicycle_ctrl #(
    parameter int ALUCTL_W    = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    arm_multicycle_ctrl_if.master bus
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_ERROR    = 4'd15;

    localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(0);
    localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(1);
    localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(2);
    localparam logic [ALUCTL_W-1:0] ALU_ORR = ALUCTL_W'(3);
    localparam logic [ALUCTL_W-1:0] ALU_MOV = ALUCTL_W'(4);
    localparam logic [ALUCTL_W-1:0] ALU_EOR = ALUCTL_W'(5);
    localparam logic [ALUCTL_W-1:0] ALU_LSL = ALUCTL_W'(6);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

    logic [3:0]       state, next_state;
    logic [3:0]       flags;
    logic [CNT_W-1:0] wait_cnt;

    logic [1:0] op;
    logic [3:0] cmd;
    logic       i_bit, s_bit, l_bit;
    logic       rd_is_pc;

    assign op       = bus.instr[27:26];
    assign i_bit    = bus.instr[25];
    assign cmd      = bus.instr[24:21];
    assign s_bit    = bus.instr[20];
    assign l_bit    = bus.instr[20];
    assign rd_is_pc = (bus.instr[15:12] == 4'hF);

    function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'h0:    cond_ok = z;
            4'h1:    cond_ok = ~z;
            4'h2:    cond_ok = c;
            4'h3:    cond_ok = ~c;
            4'h4:    cond_ok = n;
            4'h5:    cond_ok = ~n;
            4'h6:    cond_ok = v;
            4'h7:    cond_ok = ~v;
            4'h8:    cond_ok = c & ~z;
            4'h9:    cond_ok = ~c | z;
            4'hA:    cond_ok = (n == v);
            4'hB:    cond_ok = (n != v);
            4'hC:    cond_ok = ~z & (n == v);
            4'hD:    cond_ok = z | (n != v);
            default: cond_ok = 1'b1;
        endcase
    endfunction

    // Data-processing decode: ALU op, whether the result is written back, whether C/V update.
    logic [ALUCTL_W-1:0] dp_alu;
    logic                dp_write, dp_cv;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        dp_alu   = ALU_ADD;
        dp_write = 1'b1;
        dp_cv    = 1'b0;
        case (cmd)
            4'b0100: dp_cv  = 1'b1;
            4'b0010: begin dp_alu = ALU_SUB; dp_cv = 1'b1; end
            4'b0000: dp_alu = ALU_AND;
            4'b1100: dp_alu = ALU_ORR;
            4'b1101: dp_alu = ALU_MOV;
            4'b1010: begin dp_alu = ALU_SUB; dp_cv = 1'b1; dp_write = 1'b0; end
            4'b1000: begin dp_alu = ALU_AND; dp_write = 1'b0; end
            4'b0001: dp_alu = ALU_EOR;
            4'b0011: dp_alu = ALU_LSL;
            default: dp_write = 1'b0;
        endcase
    end

    logic                pc_write, adr_src, mem_write, ir_write, alu_src_a;
    logic                reg_write, link_write, mem_wait;
    logic [1:0]          result_src, alu_src_b, imm_src, reg_src;
    logic [ALUCTL_W-1:0] alu_control;

    always_comb begin
        next_state  = state;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        imm_src     = 2'b00;
        reg_src     = 2'b00;
        reg_write   = 1'b0;
        link_write  = 1'b0;
        mem_wait    = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                mem_wait   = 1'b1;
                if (bus.mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (!cond_ok(bus.instr[31:28], flags)) next_state = S_FETCH;
                else begin
                    case (op)
                        2'b01:   next_state = S_MEMADR;
                        2'b10:   next_state = S_BRANCH;
                        2'b00:   next_state = i_bit ? S_EXECI : S_EXECR;
                        default: next_state = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                alu_src_b  = 2'b01;
                imm_src    = 2'b01;
                next_state = l_bit ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src  = 1'b1;
                mem_wait = 1'b1;
                if (bus.mem_ready) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                reg_src   = 2'b10;
                mem_wait  = 1'b1;
                mem_write = bus.mem_ready;
                if (bus.mem_ready) next_state = S_FETCH;
            end
            S_EXECR: begin
                alu_control = dp_alu;
                next_state  = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_b   = 2'b01;
                alu_control = dp_alu;
                next_state  = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = dp_write;
                pc_write   = dp_write & rd_is_pc;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                reg_src    = 2'b01;
                alu_src_b  = 2'b01;
                imm_src    = 2'b10;
                result_src = 2'b10;
                pc_write   = 1'b1;
                next_state = S_FETCH;
`ifdef BRANCH_LINK_EN
                // BL: ALUOut still holds PC+4 from DECODE, so it becomes the link value.
                if (bus.instr[24]) begin
                    reg_write  = 1'b1;
                    link_write = 1'b1;
                    result_src = 2'b00;
                end
`endif
            end
            S_ERROR: next_state = S_ERROR;
            default: next_state = S_FETCH;
        endcase
        if (MEM_TIMEOUT > 0 && mem_wait && !bus.mem_ready && wait_cnt == TIMEOUT_LAST)
            next_state = S_ERROR;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FETCH;
            flags    <= 4'b0000;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            if (mem_wait && next_state == state) wait_cnt <= wait_cnt + 1'b1;
            else                                 wait_cnt <= '0;
            if ((state == S_EXECR || state == S_EXECI) && s_bit) begin
                flags[3:2] <= bus.alu_flags[3:2];
                if (dp_cv) flags[1:0] <= bus.alu_flags[1:0];
            end
        end
    end

    // NOTE: write strobes are masked by reset so nothing is committed while reset is held.
    assign bus.pc_write    = pc_write   & ~reset;
    assign bus.ir_write    = ir_write   & ~reset;
    assign bus.mem_write   = mem_write  & ~reset;
    assign bus.reg_write   = reg_write  & ~reset;
    assign bus.link_write  = link_write & ~reset;
    assign bus.adr_src     = adr_src;
    assign bus.result_src  = result_src;
    assign bus.alu_src_a   = alu_src_a;
    assign bus.alu_src_b   = alu_src_b;
    assign bus.alu_control = alu_control;
    assign bus.imm_src     = imm_src;
    assign bus.reg_src     = reg_src;
    assign bus.state_o     = state;
    assign bus.bus_error   = (state == S_ERROR);
endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Directed self-checking bench for arm_multicycle_ctrl: instruction sequences, flags, waits, timeout.
module tb_arm_multicycle_ctrl;
    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    arm_multicycle_ctrl_if #(.ALUCTL_W(3)) dut_if ();

    arm_multicycle_ctrl #(.ALUCTL_W(3), .MEM_TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] strobes;
    assign strobes = {dut_if.pc_write, dut_if.ir_write, dut_if.mem_write,
                      dut_if.reg_write, dut_if.link_write};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge: apply mem_ready, check state and strobes, advance one cycle.
    task automatic step(input string tag, input logic [3:0] st, input logic mr, input logic [4:0] strb);
        dut_if.mem_ready = mr;
        #1;
        check({tag, "/state"}, 32'(dut_if.state_o), 32'(st));
        check({tag, "/strobes"}, 32'(strobes), 32'(strb));
        @(negedge clk);
    endtask

    initial begin
        reset             = 1'b1;
        dut_if.instr      = 32'h0;
        dut_if.alu_flags  = 4'b0000;
        dut_if.mem_ready  = 1'b1;
        @(negedge clk);
        #1;
        check("rst/state", 32'(dut_if.state_o), 32'd0);
        check("rst/strobes", 32'(strobes), 32'd0);
        check("rst/bus_error", 32'(dut_if.bus_error), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // MOV R0,#0x60
        dut_if.instr = 32'hE3A00060;
        step("mov f", 4'd0, 1'b1, 5'b11000);
        step("mov d", 4'd1, 1'b1, 5'b00000);
        check("mov aluctl", 32'(dut_if.alu_control), 32'd4);
        check("mov srcb", 32'(dut_if.alu_src_b), 32'd1);
        step("mov e", 4'd7, 1'b1, 5'b00000);
        step("mov wb", 4'd8, 1'b1, 5'b00010);

        // ADDS with ALU flags Z=1,C=1
        dut_if.instr     = 32'hE0910002;
        dut_if.alu_flags = 4'b0110;
        step("adds f", 4'd0, 1'b1, 5'b11000);
        step("adds d", 4'd1, 1'b1, 5'b00000);
        check("adds srcb", 32'(dut_if.alu_src_b), 32'd0);
        step("adds e", 4'd6, 1'b1, 5'b00000);
        step("adds wb", 4'd8, 1'b1, 5'b00010);

        // MOV (S=0) with different ALU flags must leave Z set
        dut_if.instr     = 32'hE3A00060;
        dut_if.alu_flags = 4'b0000;
        step("mov2 f", 4'd0, 1'b1, 5'b11000);
        step("mov2 d", 4'd1, 1'b1, 5'b00000);
        step("mov2 e", 4'd7, 1'b1, 5'b00000);
        step("mov2 wb", 4'd8, 1'b1, 5'b00010);

        // BEQ taken
        dut_if.instr = 32'h0A000001;
        step("beq f", 4'd0, 1'b1, 5'b11000);
        step("beq d", 4'd1, 1'b1, 5'b00000);
        check("beq immsrc", 32'(dut_if.imm_src), 32'd2);
        check("beq regsrc", 32'(dut_if.reg_src), 32'd1);
        check("beq ressrc", 32'(dut_if.result_src), 32'd2);
        step("beq br", 4'd9, 1'b1, 5'b10000);

        // CMP producing Z=0
        dut_if.instr = 32'hE1500000;
        step("cmp f", 4'd0, 1'b1, 5'b11000);
        step("cmp d", 4'd1, 1'b1, 5'b00000);
        check("cmp aluctl", 32'(dut_if.alu_control), 32'd1);
        step("cmp e", 4'd6, 1'b1, 5'b00000);
        step("cmp wb", 4'd8, 1'b1, 5'b00000);

        // BEQ not taken: 2 cycles, no pc_write
        dut_if.instr = 32'h0A000001;
        step("beqn f", 4'd0, 1'b1, 5'b11000);
        step("beqn d", 4'd1, 1'b1, 5'b00000);

        // LDR with 3 wait cycles
        dut_if.instr = 32'hE5902004;
        step("ldr f", 4'd0, 1'b1, 5'b11000);
        step("ldr d", 4'd1, 1'b1, 5'b00000);
        check("ldr immsrc", 32'(dut_if.imm_src), 32'd1);
        check("ldr srcb", 32'(dut_if.alu_src_b), 32'd1);
        step("ldr adr", 4'd2, 1'b1, 5'b00000);
        check("ldr adrsrc", 32'(dut_if.adr_src), 32'd1);
        for (int i = 0; i < 3; i++) step("ldr wait", 4'd3, 1'b0, 5'b00000);
        step("ldr rd", 4'd3, 1'b1, 5'b00000);
        check("ldr ressrc", 32'(dut_if.result_src), 32'd1);
        step("ldr wb", 4'd4, 1'b1, 5'b00010);

        // STR, no wait
        dut_if.instr = 32'hE5802004;
        step("str f", 4'd0, 1'b1, 5'b11000);
        step("str d", 4'd1, 1'b1, 5'b00000);
        step("str adr", 4'd2, 1'b1, 5'b00000);
        check("str regsrc", 32'(dut_if.reg_src), 32'd2);
        step("str wr", 4'd5, 1'b1, 5'b00100);

        // Unsupported DP code (ADC): ADD, no write-back
        dut_if.instr = 32'hE0A10002;
        step("adc f", 4'd0, 1'b1, 5'b11000);
        step("adc d", 4'd1, 1'b1, 5'b00000);
        check("adc aluctl", 32'(dut_if.alu_control), 32'd0);
        step("adc e", 4'd6, 1'b1, 5'b00000);
        step("adc wb", 4'd8, 1'b1, 5'b00000);

        // MOV PC,#0x10: write to R15 also loads PC
        dut_if.instr = 32'hE3A0F010;
        step("movpc f", 4'd0, 1'b1, 5'b11000);
        step("movpc d", 4'd1, 1'b1, 5'b00000);
        step("movpc e", 4'd7, 1'b1, 5'b00000);
        step("movpc wb", 4'd8, 1'b1, 5'b10010);

        // BL
        dut_if.instr = 32'hEB000002;
        step("bl f", 4'd0, 1'b1, 5'b11000);
        step("bl d", 4'd1, 1'b1, 5'b00000);
`ifdef BRANCH_LINK_EN
        check("bl ressrc", 32'(dut_if.result_src), 32'd0);
        step("bl br", 4'd9, 1'b1, 5'b10011);
`else
        check("bl ressrc", 32'(dut_if.result_src), 32'd2);
        step("bl br", 4'd9, 1'b1, 5'b10000);
`endif

        // Fetch wait states, then STR timing out in MEMWRITE
        dut_if.instr = 32'hE5802004;
        step("to fw", 4'd0, 1'b0, 5'b00000);
        step("to fw", 4'd0, 1'b0, 5'b00000);
        step("to f", 4'd0, 1'b1, 5'b11000);
        step("to d", 4'd1, 1'b1, 5'b00000);
        step("to adr", 4'd2, 1'b1, 5'b00000);
        for (int i = 0; i < 15; i++) step("to wait", 4'd5, 1'b0, 5'b00000);
        check("to buserr", 32'(dut_if.bus_error), 32'd1);
        step("to err", 4'd15, 1'b1, 5'b00000);
        step("to held", 4'd15, 1'b1, 5'b00000);

        // Reset clears the error and returns to FETCH at once
        reset = 1'b1;
        #1;
        check("rst2/state", 32'(dut_if.state_o), 32'd0);
        check("rst2/buserr", 32'(dut_if.bus_error), 32'd0);
        check("rst2/strobes", 32'(strobes), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        dut_if.instr = 32'hE3A00060;
        step("mov3 f", 4'd0, 1'b1, 5'b11000);
        step("mov3 d", 4'd1, 1'b1, 5'b00000);
        step("mov3 e", 4'd7, 1'b1, 5'b00000);
        step("mov3 wb", 4'd8, 1'b1, 5'b00010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/arm_multicycle_ctrl.md
Name: arm_multicycle_ctrl

Overview:
FSM control unit for the multicycle ARM core, the successor to the single-cycle controller. It sequences fetch/decode/execute over shared memory and a single ALU, and holds the NZCV flags and condition check. Memory accesses wait on a ready handshake and are guarded by a timeout. It drives the multicycle datapath, which holds the IR, PC, Data and ALUOut registers.

Parameters:
ALUCTL_W, 3, width of alu_control; encodings ADD=0 SUB=1 AND=2 ORR=3 MOV=4 EOR=5 LSL=6, upper bits zero.
MEM_TIMEOUT, 15, wait-state cycles allowed per memory access before bus error; 0 disables the timeout.

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
instr  in  32  current IR contents (valid from DECODE onward)
alu_flags  in  4  {N,Z,C,V} from ALU, same cycle
mem_ready  in  1  memory completes the current access this cycle
pc_write  out  1  load PC
adr_src  out  1  0=PC, 1=ALUOut as memory address
mem_write  out  1  memory write strobe
ir_write  out  1  load IR
result_src  out  2  00=ALUOut, 01=Data, 10=ALU direct
alu_src_a  out  1  0=RD1, 1=PC
alu_src_b  out  2  00=RD2, 01=ExtImm, 10=const 4
alu_control  out  ALUCTL_W  ALU operation
imm_src  out  2  as instr decode (00 imm8, 01 imm12, 10 branch)
reg_src  out  2  {RA2=Rd for STR, RA1=R15 for B}
reg_write  out  1  register file write enable
link_write  out  1  force write address R14 (BRANCH_LINK_EN only, else 0)
state_o  out  4  current state encoding
bus_error  out  1  sticky memory timeout indication

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, ERROR=15.
- Reset: state=FETCH, flags=0000, wait counter=0, bus_error=0. All strobes (pc_write, ir_write, mem_write, reg_write, link_write) are 0 during reset.
- Strobes are Moore/Mealy on state. Only ir_write/pc_write in FETCH and mem_write in MEMWRITE additionally depend on mem_ready.
- FETCH: adr_src=0, alu_src_a=1, alu_src_b=10, ADD, result_src=10.
  - mem_ready=1: ir_write=pc_write=1, go to DECODE.
  - Otherwise stay, with strobes low.
- DECODE: alu_src_a=1, alu_src_b=10, ADD (R15 reads PC+8). CondEx is evaluated from the registered flags.
  - CondEx=0: go to FETCH (a skipped instruction costs 2 cycles).
  - op=01: MEMADR. op=10: BRANCH. op=00: EXECI if I=1, else EXECR. op=11: FETCH (NOP).
- MEMADR: alu_src_a=0, alu_src_b=01, ADD, imm_src=01. L=1 goes to MEMREAD, L=0 goes to MEMWRITE.
- MEMREAD: adr_src=1. Stay until mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: adr_src=1, reg_src[1]=1, mem_write=mem_ready. Leave for FETCH when mem_ready=1.
- EXECR: alu_src_b=00. EXECI: alu_src_b=01, imm_src=00. Both go to ALUWB.
  - alu_control decode on instr[24:21]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1101 MOV, 1010 CMP→SUB, 1000 TST→AND, 0001 EOR, 0011 LSL. Any other code gives ADD with reg_write suppressed.
  - If S=1, flags are written at the clock edge leaving EXEC*: N,Z always; C,V only for ADD/SUB/CMP.
- ALUWB: result_src=00. reg_write=1 except for CMP/TST. If Rd=15 and a write occurs, pc_write=1 as well. Then FETCH.
- BRANCH: reg_src[0]=1, alu_src_a=0, alu_src_b=01, imm_src=10, ADD, result_src=10, pc_write=1, then FETCH.
- Latencies: DP = 4 cycles, LDR = 5, STR = 4, B = 3, cond-fail = 2, each plus memory wait cycles.
- Wait counter: counts consecutive mem_ready=0 cycles in FETCH/MEMREAD/MEMWRITE and clears on state change.
  - If MEM_TIMEOUT>0 and the count reaches MEM_TIMEOUT, go to ERROR.
  - ERROR: all strobes 0, bus_error=1, held until reset.
- Reset asserted mid-instruction returns to FETCH immediately, with no partial writes after the reset edge.

Optional Feature:
BRANCH_LINK_EN.
- Defined: op=10 with instr[24]=1 (BL). In BRANCH, reg_write=1 and link_write=1 with result_src=00, so ALUOut (PC+4 from DECODE) is written to R14 in the same cycle as pc_write.
- Undefined: instr[24] is ignored, BL executes as B, and link_write is tied to 0.

Test Plan:
- E3A00060 (MOV R0,#0x60), mem_ready=1 → state_o sequence 0,1,7,8; reg_write=1 only in ALUWB; alu_control=4; flags unchanged.
- E0910002 (ADDS) with ALU flags 0110 → flags=0110 after EXECR; next 0A000001 (BEQ) → 0,1,9 with pc_write=1 in BRANCH.
- E1500000 (CMP) giving Z=0, then 0A000001 → DECODE returns to FETCH, no pc_write; CMP has reg_write=0 throughout.
- E5902004 (LDR) with mem_ready low 3 cycles in MEMREAD → 0,1,2,3,3,3,3,4,0; reg_write only in MEMWB.
- E5802004 (STR), mem_ready held 0 for 15 cycles in MEMWRITE → state_o=15, bus_error=1, mem_write never 1; reset → FETCH, bus_error=0.
- With BRANCH_LINK_EN, EB000002 (BL) → link_write=reg_write=pc_write=1 in BRANCH; without it → link_write=0, reg_write=0.
